// File: rtl/adder_tree_feeder.sv
// Serial-to-vector front end for a pipelined signed adder tree: packs a frame of samples into
// the tree's lane vector, flushes the tree once, and holds the sum on a valid/ready port.
module adder_tree_feeder #(
    parameter int unsigned INPUT_NUM = 4,
    parameter int unsigned IN_WIDTH  = 8,
    parameter int unsigned OUT_WIDTH = IN_WIDTH + $clog2(INPUT_NUM)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    input  logic [IN_WIDTH-1:0]           s_data_i,
    input  logic                          s_last_i,
    output logic                          tree_add_en_o,
    output logic [INPUT_NUM*IN_WIDTH-1:0] tree_din_o,
    input  logic [OUT_WIDTH-1:0]          tree_dout_i,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic [OUT_WIDTH-1:0]          m_data_o,
    output logic [$clog2(INPUT_NUM+1)-1:0] m_lanes_o
);

    localparam int unsigned STAGES = $clog2(INPUT_NUM);
    localparam int unsigned LaneW  = $clog2(INPUT_NUM + 1);
    localparam int unsigned IdxW   = $clog2(INPUT_NUM);
    localparam int unsigned CntW   = $clog2(STAGES + 2);

    typedef enum logic [1:0] {StCollect, StFlush, StOutput} state_e;

    state_e                          state_q, state_d;
    logic [IdxW-1:0]                 idx_q, idx_d;
    logic [INPUT_NUM*IN_WIDTH-1:0]   staging_q, staging_d;
    logic                            full_q, full_d;
    logic [CntW-1:0]                 flush_cnt_q, flush_cnt_d;
    logic                            add_en_q;
    logic [LaneW-1:0]                m_lanes_q, m_lanes_d;
    logic [LaneW-1:0]                frame_lanes_q, frame_lanes_d;

    logic             accept;
    logic             complete;
    logic [LaneW-1:0] lanes_now;

    always_comb begin
        s_ready_o = 1'b0;
        unique case (state_q)
            StCollect: s_ready_o = 1'b1;
            StFlush:   s_ready_o = 1'b0;
            StOutput:  s_ready_o = !full_q;
            default:   s_ready_o = 1'b0;
        endcase
    end

    assign accept    = s_valid_i & s_ready_o;
    assign complete  = accept & ((idx_q == IdxW'(INPUT_NUM - 1)) | s_last_i);
    assign lanes_now = LaneW'(idx_q) + LaneW'(1);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        staging_d     = staging_q;
        full_d        = full_q;
        flush_cnt_d   = flush_cnt_q;
        m_lanes_d     = m_lanes_q;
        frame_lanes_d = frame_lanes_q;

        if (accept) begin
            for (int k = 0; k < INPUT_NUM; k++) begin
                if (idx_q == IdxW'(k)) begin
                    staging_d[k*IN_WIDTH +: IN_WIDTH] = s_data_i;
                end
            end
            idx_d = complete ? '0 : idx_q + IdxW'(1);
        end

        unique case (state_q)
            StCollect: begin
                if (complete) begin
                    state_d     = StFlush;
                    flush_cnt_d = '0;
                    m_lanes_d   = lanes_now;
                end
            end
            StFlush: begin
                if (flush_cnt_q == CntW'(STAGES)) begin
                    // Tree samples the old vector on this same edge, so clearing is safe.
                    state_d   = StOutput;
                    staging_d = '0;
                    idx_d     = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q + CntW'(1);
                end
            end
            StOutput: begin
                if (complete) begin
                    full_d        = 1'b1;
                    frame_lanes_d = lanes_now;
                end
                if (m_ready_i) begin
                    if (full_q || complete) begin
                        state_d     = StFlush;
                        flush_cnt_d = '0;
                        full_d      = 1'b0;
                        m_lanes_d   = full_q ? frame_lanes_q : lanes_now;
                    end else begin
                        state_d = StCollect;
                    end
                end
            end
            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StCollect;
            idx_q         <= '0;
            staging_q     <= '0;
            full_q        <= 1'b0;
            flush_cnt_q   <= '0;
            add_en_q      <= 1'b0;
            m_lanes_q     <= '0;
            frame_lanes_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            staging_q     <= staging_d;
            full_q        <= full_d;
            flush_cnt_q   <= flush_cnt_d;
            add_en_q      <= (state_d == StFlush);
            m_lanes_q     <= m_lanes_d;
            frame_lanes_q <= frame_lanes_d;
        end
    end

    assign tree_add_en_o = add_en_q;
    assign tree_din_o    = staging_q;
    assign m_valid_o     = (state_q == StOutput);
    assign m_data_o      = tree_dout_i;
    assign m_lanes_o     = m_lanes_q;

endmodule

// File: tb/tb_adder_tree_feeder.sv
// Bench for adder_tree_feeder with a behavioural 2-stage adder tree; a scoreboard queue holds
// expected sums and lane counts, popped by a monitor on each result handshake.
module tb_adder_tree_feeder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid, s_ready, s_last;
    logic [7:0]  s_data;
    logic        tree_add_en;
    logic [31:0] tree_din;
    logic [9:0]  tree_dout;
    logic        m_valid, m_ready;
    logic [9:0]  m_data;
    logic [2:0]  m_lanes;

    int n_checks = 0;
    int n_pass   = 0;
    logic [12:0] exp_q[$];
    int en_run = 0;

    always #5 clk = ~clk;

    adder_tree_feeder #(.INPUT_NUM(4), .IN_WIDTH(8), .OUT_WIDTH(10)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid_i    (s_valid),
        .s_ready_o    (s_ready),
        .s_data_i     (s_data),
        .s_last_i     (s_last),
        .tree_add_en_o(tree_add_en),
        .tree_din_o   (tree_din),
        .tree_dout_i  (tree_dout),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
        .m_data_o     (m_data),
        .m_lanes_o    (m_lanes)
    );

    // Pipelined tree: pair sums, then total; advances only while add_en is high.
    logic signed [8:0] t1a, t1b;
    logic signed [9:0] t2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t1a <= '0;
            t1b <= '0;
            t2  <= '0;
        end else if (tree_add_en) begin
            t1a <= $signed(tree_din[7:0]) + $signed(tree_din[15:8]);
            t1b <= $signed(tree_din[23:16]) + $signed(tree_din[31:24]);
            t2  <= t1a + t1b;
        end
    end
    assign tree_dout = t2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_exp(input int sum, input int lanes);
        exp_q.push_back({3'(lanes), 10'(sum)});
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            en_run = 0;
        end else begin
            if (tree_add_en) begin
                en_run++;
            end else if (en_run != 0) begin
                chk("add_en_cycles", en_run, 3);
                en_run = 0;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    logic [12:0] e;
                    e = exp_q.pop_front();
                    chk("m_data", {22'd0, m_data}, {22'd0, e[9:0]});
                    chk("m_lanes", {29'd0, m_lanes}, {29'd0, e[12:10]});
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic last);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(negedge clk);
        while (!s_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!s_ready) chk("send_timeout", {31'd0, s_ready}, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!m_valid && n < 50) begin
            n++;
            @(posedge clk);
            #1;
        end
        if (!m_valid) chk(name, {31'd0, m_valid}, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            n++;
            @(posedge clk);
        end
        chk("queue_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: idle after reset
        @(negedge clk);
        chk("rst_s_ready", {31'd0, s_ready}, 1);
        chk("rst_m_valid", {31'd0, m_valid}, 0);
        chk("rst_add_en", {31'd0, tree_add_en}, 0);
        chk("rst_m_lanes", {29'd0, m_lanes}, 0);
        @(posedge clk);
        #1;

        // 2: full frame, latency and single-cycle result
        m_ready = 1'b1;
        send(8'd1, 1'b0);
        send(8'd2, 1'b0);
        send(8'd3, 1'b0);
        push_exp(10, 4);
        send(8'd4, 1'b0);
        cyc = 0;
        while (!m_valid && cyc < 20) begin
            cyc++;
            @(posedge clk);
            #1;
        end
        chk("latency", cyc, 3);
        @(posedge clk);
        #1;
        chk("valid_one_cycle", {31'd0, m_valid}, 0);

        // 3: most negative samples
        for (int i = 0; i < 3; i++) send(8'h80, 1'b0);
        push_exp(-512, 4);
        send(8'h80, 1'b0);
        drain();

        // 4: short frame via s_last, then next frame must restart at lane 0
        send(8'd5, 1'b0);
        push_exp(12, 2);
        send(8'd7, 1'b1);
        drain();
        push_exp(3, 1);
        send(8'd3, 1'b1);
        chk("restart_lane0", tree_din, 32'h0000_0003);
        drain();

        // 5: collect next frame while result is stalled
        m_ready = 1'b0;
        send(8'd1, 1'b0);
        send(8'd2, 1'b0);
        send(8'd3, 1'b0);
        push_exp(10, 4);
        send(8'd4, 1'b0);
        for (int i = 0; i < 3; i++) send(8'd1, 1'b0);
        push_exp(4, 4);
        send(8'd1, 1'b0);
        s_valid = 1'b1;
        s_data  = 8'd1;
        @(negedge clk);
        chk("full_s_ready", {31'd0, s_ready}, 0);
        chk("stall_m_valid", {31'd0, m_valid}, 1);
        chk("stall_m_data", {22'd0, m_data}, 32'd10);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        chk("direct_flush", {31'd0, tree_add_en}, 1);
        chk("direct_m_valid", {31'd0, m_valid}, 0);
        wait_valid("wait_second");
        m_ready = 1'b1;
        drain();

        // 6: reset in the middle of a flush discards the frame
        for (int i = 0; i < 4; i++) send(8'd9, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_add_en", {31'd0, tree_add_en}, 0);
        chk("mid_rst_m_valid", {31'd0, m_valid}, 0);
        chk("mid_rst_m_lanes", {29'd0, m_lanes}, 0);
        chk("mid_rst_din", tree_din, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_s_ready", {31'd0, s_ready}, 1);
        for (int i = 0; i < 3; i++) send(8'd2, 1'b0);
        push_exp(8, 4);
        send(8'd2, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
